// File: rtl/vga_pkg.sv
// Shared screen geometry, default colours and menu-cursor types.
package vga_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int IDX_W    = 3;

  localparam logic [7:0] DEF_FRAME_RGB  = 8'hFC;
  localparam logic [7:0] DEF_CURSOR_RGB = 8'hFC;
  localparam logic [7:0] DEF_BG_RGB     = 8'h00;
  localparam logic [7:0] DEF_BLANK_RGB  = 8'hFF;

  typedef enum logic [1:0] {
    MV_NONE = 2'b00,
    MV_UP   = 2'b01,
    MV_DOWN = 2'b10
  } move_t;

  // Wrapping step through n options; up=1 moves right.
  function automatic logic [IDX_W-1:0] step_idx(input logic [IDX_W-1:0] idx,
                                                input logic up, input int n);
    if (up)
      return (int'(idx) == n - 1) ? '0 : idx + 1'b1;
    else
      return (idx == '0) ? IDX_W'(n - 1) : idx - 1'b1;
  endfunction
endpackage

// File: rtl/menu_cursor_gen_debounce.sv
// Push-button debouncer: two-flop synchroniser plus stable-time down-counter,
// emits a one-cycle tick when the debounced level rises.
module menu_cursor_gen_debounce #(
  parameter int CYCLES = 250_000
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_tick
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CYCLES - 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_sync  <= 2'b00;
      r_level <= 1'b0;
      r_cnt   <= RELOAD;
      r_tick  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_tick <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= RELOAD;
      end else if (r_cnt == '0) begin
        r_level <= r_sync[1];
        r_cnt   <= RELOAD;
        r_tick  <= r_sync[1];
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_tick = r_tick;
endmodule

// File: rtl/menu_cursor_gen.sv
// Main-screen menu renderer: frame/divider border plus a blinking cursor box
// that steps between options on debounced button ticks, once per frame.
module menu_cursor_gen
  import vga_pkg::*;
#(
  parameter int NUM_OPTS = 5,
  parameter logic [NUM_OPTS*10-1:0] OPT_X = {10'd557, 10'd480, 10'd180, 10'd93, 10'd16},
  parameter int CURSOR_W = 57,
  parameter int CURSOR_H = 17,
  parameter int CURSOR_Y = 65,
  parameter int BORDER_T = 8,
  parameter int DIVIDER_Y = 90,
  parameter int BLINK_FRAMES = 30,
  parameter logic [7:0] FRAME_RGB  = DEF_FRAME_RGB,
  parameter logic [7:0] CURSOR_RGB = DEF_CURSOR_RGB,
  parameter logic [7:0] BG_RGB     = DEF_BG_RGB,
  parameter logic [7:0] BLANK_RGB  = DEF_BLANK_RGB,
  parameter int DEBOUNCE_CYCLES = 250_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             video_on,
  input  logic             frame_start,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pinta_pantalla_principal,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic             cerrar,
  input  logic             nuevo,
  output logic             graph_on,
  output logic [7:0]       graph_rgb,
  output logic [IDX_W-1:0] cursor_idx,
  output logic             sel_tick
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = (BLINK_FRAMES > 0) ? BW'(BLINK_FRAMES - 1) : '0;

  localparam logic [10:0] X_LEFT_END  = 11'(BORDER_T);
  localparam logic [10:0] X_RIGHT_BEG = 11'(SCREEN_W - BORDER_T);
  localparam logic [10:0] Y_TOP_END   = 11'(BORDER_T);
  localparam logic [10:0] Y_BOT_BEG   = 11'(SCREEN_H - BORDER_T);
  localparam logic [10:0] Y_DIV_BEG   = 11'(DIVIDER_Y);
  localparam logic [10:0] Y_DIV_END   = 11'(DIVIDER_Y + BORDER_T);
  localparam logic [10:0] Y_CUR_BEG   = 11'(CURSOR_Y);
  localparam logic [10:0] Y_CUR_END   = 11'(CURSOR_Y + CURSOR_H);
  localparam logic [10:0] CUR_W11     = 11'(CURSOR_W);

  logic             w_rst;
  logic             w_tick_l, w_tick_r, w_tick_s;
  logic             w_home, w_commit;
  logic [9:0]       w_opt_sel;
  logic [10:0]      w_x, w_y, w_cur_x0, w_cur_x1;
  logic             w_frame, w_cursor;
  logic [7:0]       w_rgb;

  logic [IDX_W-1:0] r_idx;
  move_t            r_pend;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_visible;
  logic             r_sel_tick;
  logic             r_graph_on;
  logic [7:0]       r_graph_rgb;

  assign w_rst = ~reset;

  menu_cursor_gen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .i_rst(w_rst), .i_btn(btn_left), .o_tick(w_tick_l));
  menu_cursor_gen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .i_rst(w_rst), .i_btn(btn_right), .o_tick(w_tick_r));
  menu_cursor_gen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
    .clk(clk), .i_rst(w_rst), .i_btn(btn_sel), .o_tick(w_tick_s));

  assign w_home   = cerrar | nuevo;
  assign w_commit = frame_start & (r_pend != MV_NONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_pend      <= MV_NONE;
      r_blink_cnt <= '0;
      r_visible   <= 1'b1;
      r_sel_tick  <= 1'b0;
    end else begin
      r_sel_tick <= w_tick_s & ~w_home;
      if (w_home) begin
        r_idx       <= '0;
        r_pend      <= MV_NONE;
        r_blink_cnt <= '0;
        r_visible   <= 1'b1;
      end else begin
        if (w_commit)
          r_idx <= step_idx(r_idx, r_pend == MV_UP, NUM_OPTS);
        // A tick landing on the frame_start cycle becomes the next pending move.
        if (w_tick_r && !w_tick_l)
          r_pend <= MV_UP;
        else if (w_tick_l && !w_tick_r)
          r_pend <= MV_DOWN;
        else if (frame_start)
          r_pend <= MV_NONE;
        if (w_commit || BLINK_FRAMES == 0) begin
          r_blink_cnt <= '0;
          r_visible   <= 1'b1;
        end else if (frame_start) begin
          if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_visible   <= ~r_visible;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_opt_sel = '0;
    for (int i = 0; i < NUM_OPTS; i++)
      if (r_idx == IDX_W'(i)) w_opt_sel = OPT_X[i*10 +: 10];
  end

  assign w_x      = {1'b0, pix_x};
  assign w_y      = {1'b0, pix_y};
  assign w_cur_x0 = {1'b0, w_opt_sel};
  assign w_cur_x1 = w_cur_x0 + CUR_W11;

  assign w_frame = pinta_pantalla_principal &
                   ((w_x < X_LEFT_END) || (w_x >= X_RIGHT_BEG) ||
                    (w_y < Y_TOP_END)  || (w_y >= Y_BOT_BEG)   ||
                    ((w_y >= Y_DIV_BEG) && (w_y < Y_DIV_END)));
  assign w_cursor = pinta_pantalla_principal & r_visible &
                    (w_x >= w_cur_x0) && (w_x < w_cur_x1) &&
                    (w_y >= Y_CUR_BEG) && (w_y < Y_CUR_END);

  always_comb begin
    w_rgb = BG_RGB;
    if (!video_on)     w_rgb = BLANK_RGB;
    else if (w_frame)  w_rgb = FRAME_RGB;
    else if (w_cursor) w_rgb = CURSOR_RGB;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_graph_on  <= 1'b0;
      r_graph_rgb <= BG_RGB;
    end else begin
      r_graph_on  <= w_frame | w_cursor;
      r_graph_rgb <= w_rgb;
    end
  end

  assign graph_on   = r_graph_on;
  assign graph_rgb  = r_graph_rgb;
  assign cursor_idx = r_idx;
  assign sel_tick   = r_sel_tick;
endmodule

// File: tb/tb_menu_cursor_gen.sv
// Self-checking bench for menu_cursor_gen against a frame-level model of the menu.
module tb_menu_cursor_gen;
  localparam int NO = 5;
  localparam int B  = 2;
  localparam int HOLD = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] pix_x = '0, pix_y = '0;
  logic       pinta = 1'b1;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic       cerrar = 1'b0, nuevo = 1'b0;
  logic       graph_on;
  logic [7:0] graph_rgb;
  logic [2:0] cursor_idx;
  logic       sel_tick;

  int checks = 0;
  int failures = 0;

  int opt_x [NO] = '{16, 93, 180, 480, 557};
  int m_idx = 0;
  int m_pend = 0;
  int m_frames = 0;

  always #5 clk = ~clk;

  menu_cursor_gen #(.BLINK_FRAMES(B), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .frame_start(frame_start),
    .pix_x(pix_x), .pix_y(pix_y), .pinta_pantalla_principal(pinta),
    .btn_left(btn_left), .btn_right(btn_right), .btn_sel(btn_sel),
    .cerrar(cerrar), .nuevo(nuevo), .graph_on(graph_on), .graph_rgb(graph_rgb),
    .cursor_idx(cursor_idx), .sel_tick(sel_tick));

  function automatic bit m_visible();
    return ((m_frames / B) % 2) == 0;
  endfunction

  function automatic bit m_frame(int x, int y, bit pint);
    return pint && (x < 8 || x >= 632 || y < 8 || y >= 472 || (y >= 90 && y < 98));
  endfunction

  function automatic bit m_cursor(int x, int y, bit pint);
    return pint && m_visible() && x >= opt_x[m_idx] && x < opt_x[m_idx] + 57 &&
           y >= 65 && y < 82;
  endfunction

  function automatic logic [7:0] m_rgb(int x, int y, bit von, bit pint);
    if (!von) return 8'hFF;
    if (m_frame(x, y, pint)) return 8'hFC;
    if (m_cursor(x, y, pint)) return 8'hFC;
    return 8'h00;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx = 0; m_pend = 0; m_frames = 0;
  endtask

  task automatic press(input bit l, input bit r, input bit s);
    btn_left = l; btn_right = r; btn_sel = s;
    cyc(HOLD);
    btn_left = 0; btn_right = 0; btn_sel = 0;
    cyc(HOLD);
    if (l && !r) m_pend = -1;
    else if (r && !l) m_pend = 1;
  endtask

  task automatic frame_pulse();
    frame_start = 1;
    cyc(1);
    frame_start = 0;
    if (m_pend != 0) begin
      m_idx = (m_idx + m_pend + NO) % NO;
      m_pend = 0;
      m_frames = 0;
    end else begin
      m_frames++;
    end
  endtask

  task automatic home(input bit use_nuevo);
    if (use_nuevo) nuevo = 1; else cerrar = 1;
    cyc(1);
    nuevo = 0; cerrar = 0;
    model_reset();
  endtask

  task automatic check_idx(input string name);
    checks++;
    if (cursor_idx !== 3'(m_idx)) begin
      failures++;
      $display("FAIL %s: cursor_idx=%0d expected=%0d", name, cursor_idx, m_idx);
    end
  endtask

  task automatic check_pixel(input string name, input int x, input int y);
    logic [7:0] exp_rgb;
    bit exp_on;
    pix_x = 10'(x); pix_y = 10'(y);
    exp_rgb = m_rgb(x, y, video_on, pinta);
    exp_on = m_frame(x, y, pinta) || m_cursor(x, y, pinta);
    cyc(1);
    checks++;
    if (graph_rgb !== exp_rgb || graph_on !== exp_on) begin
      failures++;
      $display("FAIL %s (%0d,%0d): rgb=%h on=%b expected rgb=%h on=%b",
               name, x, y, graph_rgb, graph_on, exp_rgb, exp_on);
    end
  endtask

  task automatic test_reset();
    reset = 0;
    cyc(3);
    checks++;
    if (cursor_idx !== 3'd0 || sel_tick !== 1'b0 || graph_on !== 1'b0 || graph_rgb !== 8'h00) begin
      failures++;
      $display("FAIL reset: idx=%0d sel=%b on=%b rgb=%h expected 0 0 0 00",
               cursor_idx, sel_tick, graph_on, graph_rgb);
    end
    reset = 1;
    model_reset();
    cyc(2);
  endtask

  task automatic test_mid_frame_move();
    press(0, 1, 0);
    check_idx("move_before_frame");
    frame_pulse();
    check_idx("move_after_frame");
    check_pixel("cursor_left_edge", 93, 70);
    check_pixel("cursor_right_edge", 149, 70);
    check_pixel("cursor_past_right", 150, 70);
    check_pixel("cursor_before_left", 92, 70);
    check_pixel("cursor_top", 100, 65);
    check_pixel("cursor_below", 100, 82);
  endtask

  task automatic test_wrap();
    press(1, 0, 0); frame_pulse();
    check_idx("left_to_0");
    press(1, 0, 0); frame_pulse();
    check_idx("left_wrap_to_4");
    press(0, 1, 0); frame_pulse();
    check_idx("right_wrap_to_0");
  endtask

  task automatic test_both();
    press(0, 1, 0); frame_pulse();
    press(1, 1, 0); frame_pulse();
    check_idx("both_unchanged");
  endtask

  task automatic test_home_priority();
    home(1);
    repeat (3) begin press(0, 1, 0); frame_pulse(); end
    check_idx("at_idx3");
    frame_pulse(); frame_pulse();
    press(0, 1, 0);
    nuevo = 1; frame_start = 1;
    cyc(1);
    nuevo = 0; frame_start = 0;
    model_reset();
    check_idx("home_over_move");
    check_pixel("home_visible", 20, 70);
    frame_pulse();
    check_idx("home_cleared_pending");
  endtask

  task automatic test_blink();
    home(0);
    for (int f = 0; f < 8; f++) begin
      logic [7:0] exp_c;
      exp_c = ((f / 2) % 2 == 0) ? 8'hFC : 8'h00;
      pix_x = 10'd20; pix_y = 10'd70;
      cyc(1);
      checks++;
      if (graph_rgb !== exp_c) begin
        failures++;
        $display("FAIL blink_cursor frame %0d: rgb=%h expected=%h", f, graph_rgb, exp_c);
      end
      pix_x = 10'd3; pix_y = 10'd200;
      cyc(1);
      checks++;
      if (graph_rgb !== 8'hFC) begin
        failures++;
        $display("FAIL blink_frame frame %0d: rgb=%h expected=fc", f, graph_rgb);
      end
      frame_pulse();
    end
  endtask

  task automatic test_boundaries();
    int xs [6] = '{7, 8, 631, 632, 300, 639};
    int ys [6] = '{200, 200, 200, 200, 97, 479};
    for (int i = 0; i < 6; i++) check_pixel("border", xs[i], ys[i]);
    check_pixel("divider_top", 300, 90);
    check_pixel("below_divider", 300, 98);
    check_pixel("top_border", 300, 7);
    check_pixel("under_top", 300, 8);
  endtask

  task automatic test_gating();
    pinta = 0;
    check_pixel("pinta_off_frame", 3, 200);
    pinta = 1;
    video_on = 0;
    check_pixel("video_off", 3, 200);
    check_pixel("video_off_bg", 300, 300);
    video_on = 1;
  endtask

  task automatic count_sel(input string name, input bit hold_nuevo, input int exp_cnt);
    int cnt, run, max_run;
    cnt = 0; run = 0; max_run = 0;
    nuevo = hold_nuevo;
    btn_sel = 1;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (i == HOLD) btn_sel = 0;
      cyc(1);
      if (sel_tick === 1'b1) begin
        cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
    nuevo = 0;
    if (hold_nuevo) model_reset();
    checks++;
    if (cnt != exp_cnt || max_run > 1) begin
      failures++;
      $display("FAIL %s: pulses=%0d longest=%0d expected pulses=%0d longest<=1",
               name, cnt, max_run, exp_cnt);
    end
  endtask

  task automatic test_sel();
    count_sel("sel_pulse", 0, 1);
    check_idx("sel_no_move");
    count_sel("sel_suppressed", 1, 0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0: press(1, 0, 0);
        1: press(0, 1, 0);
        2: press(1, 1, 0);
        3: frame_pulse();
        4: if ($urandom_range(0, 3) == 0) home($urandom_range(0, 1) == 1); else frame_pulse();
        default: press(0, 0, 1);
      endcase
      check_idx("random_idx");
      if ($urandom_range(0, 1) == 1)
        check_pixel("random_cursor_px", opt_x[$urandom_range(0, NO - 1)] + $urandom_range(0, 60),
                    $urandom_range(60, 85));
      else
        check_pixel("random_px", $urandom_range(0, 639), $urandom_range(0, 479));
    end
  endtask

  task automatic test_reset_inflight();
    home(1);
    repeat (3) begin press(0, 1, 0); frame_pulse(); end
    check_idx("three_moves");
    frame_pulse();
    press(0, 1, 0);
    pix_x = 10'd500; pix_y = 10'd70;
    reset = 0;
    cyc(1);
    checks++;
    if (cursor_idx !== 3'd0 || sel_tick !== 1'b0 || graph_rgb !== 8'h00) begin
      failures++;
      $display("FAIL reset_inflight: idx=%0d sel=%b rgb=%h expected 0 0 00",
               cursor_idx, sel_tick, graph_rgb);
    end
    reset = 1;
    model_reset();
    frame_pulse();
    check_idx("reset_dropped_pending");
    check_pixel("reset_visible", 20, 70);
  endtask

  initial begin
    test_reset();
    test_mid_frame_move();
    test_wrap();
    test_both();
    test_home_priority();
    test_blink();
    test_boundaries();
    test_gating();
    test_sel();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
